// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - constants and ALU control encodings shared by the LEGv8 datapath and bench
package register_file_pkg;

  localparam logic [4:0] XZR_ADDR  = 5'd31;
  localparam int         REG_COUNT = 32;
  localparam int         WIDTH     = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } aluCtlT;

endpackage

// File: rtl/register_file_read_port.sv
// rtl/register_file_read_port.sv - one combinational read port: address decode, XZR mux, write bypass
module register_file_read_port #(
  parameter int WIDTH      = register_file_pkg::WIDTH,
  parameter int DEPTH_LOG2 = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      regs [2**DEPTH_LOG2],
  input  logic [DEPTH_LOG2-1:0] writeAddr,
  input  logic                  writeHit,
  input  logic [WIDTH-1:0]      writeData,
  output logic [WIDTH-1:0]      data
);
  import register_file_pkg::*;

  localparam logic [DEPTH_LOG2-1:0] XzrAddr = DEPTH_LOG2'(XZR_ADDR);

  // writeHit already excludes XZR, but the XZR check still comes first so X31 can never leak data
  always_comb begin
    data = regs[addr];
    if (addr == XzrAddr) begin
      data = '0;
    end else if (BYPASS && writeHit && (addr == writeAddr)) begin
      data = writeData;
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 64 LEGv8 register file: two combinational reads, one write, X31 = zero
module register_file #(
  parameter int WIDTH      = register_file_pkg::WIDTH,
  parameter int DEPTH_LOG2 = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DEPTH_LOG2-1:0] RA,
  input  logic [DEPTH_LOG2-1:0] RB,
  input  logic [DEPTH_LOG2-1:0] RW,
  input  logic                  RegWr,
  input  logic [WIDTH-1:0]      BusW,
  output logic [WIDTH-1:0]      BusA,
  output logic [WIDTH-1:0]      BusB,
  input  logic [DEPTH_LOG2-1:0] DbgRA,
  output logic [WIDTH-1:0]      DbgData
);
  import register_file_pkg::*;

  localparam int                    RegCount = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] XzrAddr  = DEPTH_LOG2'(XZR_ADDR);

  logic [WIDTH-1:0] regs [RegCount];
  logic             writeHit;

  assign writeHit = RegWr && (RW != XzrAddr);

  // Entry 31 is cleared by reset and never written, so it stays zero as well
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < RegCount; i++) begin
        regs[i] <= '0;
      end
      DbgData <= '0;
    end else begin
      if (writeHit) begin
        regs[RW] <= BusW;
      end
      DbgData <= (DbgRA == XzrAddr) ? '0 : regs[DbgRA];
    end
  end

  register_file_read_port #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(BYPASS)
  ) portA (
    .addr(RA), .regs(regs), .writeAddr(RW), .writeHit(writeHit),
    .writeData(BusW), .data(BusA)
  );

  register_file_read_port #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(BYPASS)
  ) portB (
    .addr(RB), .regs(regs), .writeAddr(RW), .writeHit(writeHit),
    .writeData(BusW), .data(BusB)
  );

endmodule
